// File: rtl/pb_press_decoder_pkg.sv
// Shared push-button definitions: gesture states and default timing
// constants, also used by the kitchen-timer controller.
package pb_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        PRESSED   = 2'd1,
        LONG_HELD = 2'd2
    } pb_press_state_t;

    localparam int PB_LONG_CYCLES_100M   = 100_000_000;
    localparam int PB_REPEAT_CYCLES_100M = 20_000_000;

    function automatic int pb_max(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/pb_press_decoder_if.sv
// Debounced button inputs and decoded gesture events between the
// debouncer bank (master) and the press decoder (slave).
interface pb_press_decoder_if;

    logic pb_state;
    logic pb_down;
    logic pb_up;
    logic short_press;
    logic long_press;
    logic repeat_tick;
    logic held;
    logic held_long;

    modport master (
        output pb_state,
        output pb_down,
        output pb_up,
        input  short_press,
        input  long_press,
        input  repeat_tick,
        input  held,
        input  held_long
    );

    modport slave (
        input  pb_state,
        input  pb_down,
        input  pb_up,
        output short_press,
        output long_press,
        output repeat_tick,
        output held,
        output held_long
    );

endinterface

// File: rtl/pb_press_decoder.sv
// Turns debounced press/release pulses into short-press, long-press
// and auto-repeat events, one event per gesture.
module pb_press_decoder
    import pb_pkg::*;
#(
    parameter int LONG_CYCLES   = PB_LONG_CYCLES_100M,
    parameter int REPEAT_CYCLES = PB_REPEAT_CYCLES_100M
) (
    input  logic               clk,
    input  logic               reset,
    pb_press_decoder_if.slave  pb
);

    localparam int MAXC = pb_max(LONG_CYCLES, REPEAT_CYCLES);
    localparam int CW   = (MAXC > 2) ? $clog2(MAXC) : 1;

    localparam logic [CW-1:0] LONG_LAST   = CW'(LONG_CYCLES - 1);
    localparam logic [CW-1:0] REPEAT_LAST = CW'(REPEAT_CYCLES - 1);

    generate
        if (LONG_CYCLES < 2 || REPEAT_CYCLES < 2) begin : g_param_check
            $error("pb_press_decoder: LONG_CYCLES and REPEAT_CYCLES must be >= 2");
        end
    endgenerate

    pb_press_state_t state;
    logic [CW-1:0]   cnt;
    logic            short_q;
    logic            long_q;
    logic            tick_q;
    logic            held_q;
    logic            held_long_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            cnt         <= '0;
            short_q     <= 1'b0;
            long_q      <= 1'b0;
            tick_q      <= 1'b0;
            held_q      <= 1'b0;
            held_long_q <= 1'b0;
        end else begin
            short_q     <= 1'b0;
            long_q      <= 1'b0;
            tick_q      <= 1'b0;
            // levels trail the state by a cycle, except held_long on entry
            held_q      <= (state != IDLE);
            held_long_q <= (state == LONG_HELD);
            unique case (state)
                IDLE: begin
                    if (pb.pb_down) begin
                        state <= PRESSED;
                        cnt   <= '0;
                    end
                end
                PRESSED: begin
                    if (pb.pb_up) begin
                        state   <= IDLE;
                        short_q <= 1'b1;
                    end else if (!pb.pb_state) begin
                        state <= IDLE;
                    end else if (cnt == LONG_LAST) begin
                        state       <= LONG_HELD;
                        long_q      <= 1'b1;
                        held_long_q <= 1'b1;
                        cnt         <= '0;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                LONG_HELD: begin
                    if (pb.pb_up || !pb.pb_state) begin
                        state <= IDLE;
                    end else if (cnt == REPEAT_LAST) begin
                        tick_q <= 1'b1;
                        cnt    <= '0;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

    assign pb.short_press = short_q;
    assign pb.long_press  = long_q;
    assign pb.repeat_tick = tick_q;
    assign pb.held        = held_q;
    assign pb.held_long   = held_long_q;

endmodule

// File: doc/pb_press_decoder.md
# pb_press_decoder

Consumes the clean, clock-synchronous pulses produced by the push-button debouncer (press pulse, release pulse, debounced level) and turns each button gesture into one-cycle user-action events: short press, long press, and auto-repeat ticks while a long press is held. It sits between the debouncer bank and the kitchen-timer control FSM, so the controller sees one event per gesture and never counts raw edges.

## Interface
- LONG_CYCLES, default 100_000_000: hold duration in clocks that qualifies as a long press (1 s at 100 MHz); must be ≥ 2.
- REPEAT_CYCLES, default 20_000_000: auto-repeat period in clocks after a long press (200 ms); must be ≥ 2.

- clk  input  1  100 MHz system clock.
- reset  input  1  synchronous, active-high reset.
- pb_state  input  1  debounced level, 1 while the button is down.
- pb_down  input  1  one-cycle pulse, button just pressed.
- pb_up  input  1  one-cycle pulse, button just released; arrives while pb_state is still 1.
- short_press  output  1  one-cycle pulse, released before LONG_CYCLES.
- long_press  output  1  one-cycle pulse, held for LONG_CYCLES.
- repeat_tick  output  1  one-cycle pulse every REPEAT_CYCLES while still held after long_press.
- held  output  1  level, 1 in states PRESSED and LONG_HELD.
- held_long  output  1  level, 1 in state LONG_HELD.

## Operation
- States: IDLE, PRESSED, LONG_HELD. Counter cnt, width $clog2(max(LONG_CYCLES, REPEAT_CYCLES)).
- IDLE: pb_down=1 → PRESSED, cnt←0. pb_up and pb_state are ignored.
- PRESSED, evaluated in priority order:
  1. pb_up=1 → IDLE, short_press←1.
  2. pb_state=0 → IDLE, no pulse (abort on a lost release).
  3. cnt==LONG_CYCLES-1 → LONG_HELD, long_press←1, cnt←0.
  4. Otherwise cnt←cnt+1.
- LONG_HELD, evaluated in priority order:
  1. pb_up=1 → IDLE, no pulse.
  2. pb_state=0 → IDLE, no pulse.
  3. cnt==REPEAT_CYCLES-1 → repeat_tick←1, cnt←0.
  4. Otherwise cnt←cnt+1.
- pb_down outside IDLE is ignored; it does not restart cnt.
- All outputs are registered. Pulse outputs default to 0 on every cycle not listed above.
- Exactly one of short_press or long_press is produced per completed gesture; an aborted gesture produces neither.
- Counter never wraps: it is cleared at each terminal count.

## Timing
- Reset: synchronous and active-high. State←IDLE, cnt←0, and short_press, long_press, repeat_tick, held, held_long all ←0 at the next clk edge. Reset dominates all inputs, including mid-gesture; no pulse is emitted on the edge that applies reset.
- held rises 1 clock after the edge sampling pb_down.
- short_press is high for the 1 cycle following the edge that samples pb_up.
- long_press rises exactly LONG_CYCLES clocks after the edge that sampled pb_down. held_long rises on the same edge.
- First repeat_tick comes REPEAT_CYCLES clocks after long_press rises, then every REPEAT_CYCLES clocks.
- Boundary: pb_up sampled on the same edge where cnt==LONG_CYCLES-1 → short_press only, no long_press.
- Boundary: pb_up coincident with the repeat terminal count → no repeat_tick.
- held and held_long fall 1 clock after the edge sampling pb_up or the abort condition.

## Structure
- Shared package pb_pkg: state enum pb_press_state_t (IDLE, PRESSED, LONG_HELD) and default timing constants (PB_LONG_CYCLES_100M, PB_REPEAT_CYCLES_100M), reused by the timer controller.
- Single module, no sub-module: one FSM plus one terminal counter.
- Elaboration-time check fails if LONG_CYCLES<2 or REPEAT_CYCLES<2.

## Test plan
All scenarios use LONG_CYCLES=8, REPEAT_CYCLES=4.
- Short press: pb_down at edge 0, pb_up at edge 3 → short_press high for 1 cycle after edge 3; long_press never fires; held high after edges 1–3, low after edge 4.
- Long press with repeats: pb_down at edge 0, held for 20 clocks → long_press after edge 8; repeat_tick after edges 12, 16, 20; pb_up at edge 21 → no further pulse; held_long low after edge 22.
- Short/long boundary: pb_down at edge 0, pb_up at edge 8 → short_press only; no long_press.
- Repeat boundary: pb_up coincident with the edge-12 terminal count → no repeat_tick; state returns to IDLE.
- Abort and ignores:
  - pb_state drops without pb_up in PRESSED → no pulses, held=0 next cycle.
  - Extra pb_down in PRESSED → timing unchanged.
  - pb_up in IDLE → nothing.
- Reset mid-gesture: reset at edge 5 of a press → all outputs 0 after edge 5. A later pb_up produces nothing. A fresh pb_down restarts the gesture, with long_press 8 clocks after it.
